free_reg_release_queue: RTL
===========================

// Module: free_reg_release_queue
// PURPOSE
//  Writer side of the physical-register free-list protocol. Collects old destination phregs from
//  up to two committing instructions per cycle and buffers them in a small in-order FIFO.
//  Drains up to two per cycle onto the free list's add_free_register / free_register inputs.
//  Holds, never drops, released registers while a commit roll-back is in progress.
// PARAMETERS
//  PHREG_W  6  width of phreg_t (physical register index)
//  DEPTH    8  FIFO entries; power of two, >= 4
// PORTS
//  clk_i                clk_i  in   1            clock
//  rst_i                in   1            synchronous reset, active-high
//  commit_valid_i       in   2            lane k commits this cycle; lane 0 older
//  commit_regfile_we_i  in   2            lane k wrote a destination register
//  commit_old_phreg_i   in   2xPHREG_W    previous mapping of lane k's destination
//  commit_roll_back_i   in   1            free list is rolling back: suspend draining
//  add_free_register_o  out  2            slot k valid toward free list
//  free_register_o      out  2xPHREG_W    slot k phreg; slot 0 older
//  full_o               out  1            cannot accept two pushes next cycle
//  empty_o              out  1            FIFO holds no entries
//  count_o              out  log2(DEPTH)+1  occupancy
//  overflow_o           out  1            sticky: a push was dropped for lack of space
// BEHAVIOUR
//  - Reset (rst_i=1 at posedge): head, tail, count=0; overflow_o=0. All outputs read 0,
//    except empty_o=1. Reset mid-operation discards all queued entries.
//  - Lane k is eligible when commit_valid_i[k] & commit_regfile_we_i[k] & old_phreg!=0.
//    phreg 0 is never released.
//  - Enqueue: eligible lanes are compacted in age order. If only lane 1 is eligible, it is
//    written at tail. If both are eligible, lane 0 goes to tail and lane 1 to tail+1.
//    tail advances by the number of eligible lanes, modulo DEPTH.
//  - Space check uses the registered count only; same-cycle dequeues do not create space.
//    Free space = DEPTH-count.
//    When eligible > free space, lane 0 is kept if space>=1. Excess lanes are dropped and
//    overflow_o is set; it is cleared only by reset.
//  - Drain (combinational from registered state):
//    add_free_register_o[0] = (count>=1) & ~commit_roll_back_i.
//    add_free_register_o[1] = (count>=2) & ~commit_roll_back_i.
//    free_register_o[0]=mem[head]; free_register_o[1]=mem[head+1].
//    Invalid slots drive 0.
//    The free list always accepts, so head advances by popcount(add_free_register_o) at the
//    clock edge.
//  - count_next = count + enq - deq. Width log2(DEPTH)+1 so DEPTH is representable.
//    Pointers wrap naturally.
//  - full_o = (count > DEPTH-2). empty_o = (count==0). Both are registered-state functions.
//  - Roll-back: entries are retained and enqueue continues. Draining resumes the cycle after
//    commit_roll_back_i falls.
//  - Latency without bypass: a pushed phreg appears on free_register_o the cycle after commit.
//  - Simultaneous push and drain at count=DEPTH-1: the push is limited by registered space=1.
//    Lane 1 is dropped if eligible.
// CONFIGURATION
//  FREE_RELEASE_BYPASS_EN defined:
//    - When count==0 and ~commit_roll_back_i, eligible lanes are driven directly onto the
//      outputs (compacted, slot 0 older) in the same cycle. They are not enqueued.
//    - When count!=0 or during roll-back, behaviour is identical to the non-bypass case.
//  Undefined: all releases go through the FIFO; minimum latency is 1 cycle.
// TESTING
//  1) Reset, then lane0 commits phreg 33 -> next cycle add=2'b01, free_register_o[0]=33.
//     Following cycle empty_o=1.
//  2) Both lanes commit 40,41 for 4 cycles with no roll-back -> outputs pair (40,41) each
//     cycle; count stays <= 2; overflow_o=0.
//  3) Lane0 old_phreg=0 and lane1=45 -> only 45 is enqueued, at slot 0; count=1.
//  4) Hold commit_roll_back_i for 3 cycles while pushing 2/cycle (DEPTH=8) -> add=0 and
//     count reaches 6.
//     After release, the 6 entries drain in order, 2 per cycle.
//  5) Fill to count=7, push 2 -> one entry is accepted and one dropped; overflow_o=1 and
//     stays 1 until rst_i.
//  6) With FREE_RELEASE_BYPASS_EN and an empty FIFO, push 50,51 -> same-cycle add=2'b11 with
//     (50,51); count stays 0.

Source files
------------

// File: rtl/free_reg_release_queue.sv
// free_reg_release_queue: writer side of the physical-register free-list protocol.
// Collects old destination phregs from up to two committing lanes per cycle into a
// small in-order FIFO. Drains up to two per cycle toward the free list. Draining is
// held off while a commit roll-back is in progress, and no entry is lost meanwhile.
//
// Handshake: the free list always accepts. Each asserted add_free_register_o bit is a
// completed transfer at the next rising clk edge. There is no back-pressure toward commit.
// A push that finds no registered space is dropped, and overflow_o latches until reset.
//
// Optional feature: define FREE_RELEASE_BYPASS_EN to drive eligible lanes straight to the
// outputs when the FIFO is empty and no roll-back is active.
module free_reg_release_queue #(
    parameter int PHREG_W = 6,
    parameter int DEPTH   = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [1:0]                   commit_valid_i,
    input  logic [1:0]                   commit_regfile_we_i,
    input  logic [1:0][PHREG_W-1:0]      commit_old_phreg_i,
    input  logic                         commit_roll_back_i,
    output logic [1:0]                   add_free_register_o,
    output logic [1:0][PHREG_W-1:0]      free_register_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic                         overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PHREG_W-1:0] mem [DEPTH];
    logic [AW-1:0]      head;
    logic [AW-1:0]      tail;
    logic [CW-1:0]      count;
    logic               overflow;

    logic [1:0]         elig;
    logic [CW-1:0]      n_elig;
    logic [CW-1:0]      space;
    logic [CW-1:0]      n_acc;
    logic [CW-1:0]      n_deq;
    logic               drop;
    logic               bypass;
    logic [PHREG_W-1:0] wr0;
    logic [PHREG_W-1:0] wr1;
    logic [AW-1:0]      head_p1;
    logic [AW-1:0]      tail_p1;

    // Lane eligibility: phreg 0 is hard-wired and never goes back to the free list.
    assign elig[0] = commit_valid_i[0] & commit_regfile_we_i[0] & (commit_old_phreg_i[0] != '0);
    assign elig[1] = commit_valid_i[1] & commit_regfile_we_i[1] & (commit_old_phreg_i[1] != '0);

    assign head_p1 = head + AW'(1);
    assign tail_p1 = tail + AW'(1);

    // Enqueue sizing, drain slots, and the optional empty-queue bypass.
    always_comb begin
        n_elig = CW'(elig[0]) + CW'(elig[1]);
        space  = CW'(DEPTH) - count;
        bypass = 1'b0;
`ifdef FREE_RELEASE_BYPASS_EN
        bypass = (count == '0) && !commit_roll_back_i;
`endif
        // Compact eligible lanes in age order: the oldest eligible lane is written first.
        wr0 = elig[0] ? commit_old_phreg_i[0] : commit_old_phreg_i[1];
        wr1 = commit_old_phreg_i[1];

        // Space comes from the registered count only, so a same-cycle drain frees nothing.
        if (bypass) begin
            n_acc = '0;
            drop  = 1'b0;
        end else if (n_elig <= space) begin
            n_acc = n_elig;
            drop  = 1'b0;
        end else begin
            n_acc = space;
            drop  = 1'b1;
        end

        add_free_register_o[0] = (count >= CW'(1)) && !commit_roll_back_i;
        add_free_register_o[1] = (count >= CW'(2)) && !commit_roll_back_i;
        free_register_o[0]     = add_free_register_o[0] ? mem[head]    : '0;
        free_register_o[1]     = add_free_register_o[1] ? mem[head_p1] : '0;

        if (bypass) begin
            add_free_register_o[0] = (n_elig != '0);
            add_free_register_o[1] = (n_elig == CW'(2));
            free_register_o[0]     = add_free_register_o[0] ? wr0 : '0;
            free_register_o[1]     = add_free_register_o[1] ? wr1 : '0;
            n_deq                  = '0;
        end else begin
            n_deq = CW'(add_free_register_o[0]) + CW'(add_free_register_o[1]);
        end
    end

    // Storage writes. Entries need no reset because count gates every read.
    always_ff @(posedge clk_i) begin
        if (n_acc >= CW'(1)) mem[tail]    <= wr0;
        if (n_acc == CW'(2)) mem[tail_p1] <= wr1;
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            tail     <= tail + AW'(n_acc);
            head     <= head + AW'(n_deq);
            count    <= count + n_acc - n_deq;
            overflow <= overflow | drop;
        end
    end

    assign count_o    = count;
    assign overflow_o = overflow;
    assign empty_o    = (count == '0);
    assign full_o     = (count > CW'(DEPTH - 2));

endmodule
